// File: rtl/zbt_master_pkg.sv
// Shared ZBT master parameters (LOG_ADDR, LOG_MEM, ZBT_RD_LATENCY) and arbiter types.
// Macros are guarded so a project-wide params header may define them first.
`ifndef LOG_ADDR
`define LOG_ADDR 8
`endif
`ifndef LOG_MEM
`define LOG_MEM 16
`endif
`ifndef ZBT_RD_LATENCY
`define ZBT_RD_LATENCY 3
`endif

package zbt_master_pkg;
  localparam int ADDR_W = `LOG_ADDR;
  localparam int DATA_W = `LOG_MEM;
  localparam int STAGES = `ZBT_RD_LATENCY;

  typedef enum logic {
    PRI_RD = 1'b0,
    PRI_WR = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_WR   = 2'b01,
    GNT_RD   = 2'b10
  } gnt_e;

  // Grant for the uncontended case: whichever single client is requesting.
  function automatic gnt_e sole_grant(input logic rd_valid, input logic wr_valid);
    if (rd_valid) return GNT_RD;
    if (wr_valid) return GNT_WR;
    return GNT_NONE;
  endfunction
endpackage

// File: rtl/zbt_rd_pipe.sv
// Read-return tracker: in-flight shift register of accepted reads plus rd_data capture.
// Bit N of vld_p is pipeline stage N; the last stage is the rd_data_valid strobe.
module zbt_rd_pipe #(
  parameter int DATA_W = `LOG_MEM,
  parameter int STAGES = `ZBT_RD_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              accept,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data
);
  logic [STAGES-1:0] vld_p;

  always_ff @(posedge clock) begin
    if (reset) vld_p <= '0;
    else       vld_p <= {vld_p[STAGES-2:0], accept};
  end

  // Stage STAGES-2 marks the edge where the SRAM word is on mem_data.
  always_ff @(posedge clock) begin
    if (reset)                   rd_data <= '0;
    else if (vld_p[STAGES-2])    rd_data <= mem_data;
  end

  assign rd_data_valid = vld_p[STAGES-1];
endmodule

// File: rtl/zbt_master.sv
// ZBT SRAM master: arbitrates one read and one write client onto a registered ZBT command.
// Optional feature macro ZBT_RR_ARB_EN: round-robin on contention (default: reads win).
module zbt_master
  import zbt_master_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rd_valid,
  input  logic [`LOG_ADDR-1:0] rd_addr,
  output logic                 rd_ready,
  output logic                 rd_data_valid,
  output logic [`LOG_MEM-1:0]  rd_data,
  input  logic                 wr_valid,
  input  logic [`LOG_ADDR-1:0] wr_addr,
  input  logic [`LOG_MEM-1:0]  wr_data,
  output logic                 wr_ready,
  output logic                 mem_wr,
  output logic [`LOG_ADDR-1:0] mem_addr,
  output logic [`LOG_MEM-1:0]  mem_write,
  input  logic [`LOG_MEM-1:0]  mem_data
);
  gnt_e gnt;
  logic rd_acc;
  logic wr_acc;

`ifdef ZBT_RR_ARB_EN
  arb_state_e state, state_next;

  always_ff @(posedge clock) begin
    if (reset) state <= PRI_RD;
    else       state <= state_next;
  end

  // The pointer only moves on a contended accept.
  always_comb begin
    state_next = state;
    gnt        = GNT_NONE;
    if (!reset) begin
      if (rd_valid && wr_valid) begin
        gnt        = (state == PRI_RD) ? GNT_RD : GNT_WR;
        state_next = (state == PRI_RD) ? PRI_WR : PRI_RD;
      end else begin
        gnt = sole_grant(rd_valid, wr_valid);
      end
    end
  end
`else
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) gnt = sole_grant(rd_valid, wr_valid);
  end
`endif

  // Ready is only raised toward a valid client, so ready alone marks an accept.
  assign rd_acc   = (gnt == GNT_RD);
  assign wr_acc   = (gnt == GNT_WR);
  assign rd_ready = rd_acc;
  assign wr_ready = wr_acc;

  // ---- command stage: ZBT address/control/write-data registered on accept edge
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_write <= '0;
    end else begin
      mem_wr <= wr_acc;
      if (rd_acc) begin
        mem_addr <= rd_addr;
      end else if (wr_acc) begin
        mem_addr  <= wr_addr;
        mem_write <= wr_data;
      end
    end
  end

  // ---- return stage: in-flight tracking and data capture
  zbt_rd_pipe #(
    .DATA_W(DATA_W),
    .STAGES(STAGES)
  ) u_rd_pipe (
    .clock        (clock),
    .reset        (reset),
    .accept       (rd_acc),
    .mem_data     (mem_data),
    .rd_data_valid(rd_data_valid),
    .rd_data      (rd_data)
  );
endmodule
